// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, FSM state types and floor map
// shared by the PS/2 receiver and the floor decoder.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_KEY0  = 8'h45;
  localparam logic [7:0] SC_KEY1  = 8'h16;
  localparam logic [7:0] SC_KEY2  = 8'h1E;
  localparam logic [7:0] SC_KEY3  = 8'h26;
  localparam logic [7:0] SC_KEY4  = 8'h25;
  localparam logic [7:0] SC_KEY5  = 8'h2E;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DONE
  } rx_state_e;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BREAK,
    DEC_EXT
  } dec_state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] floor;
  } floor_t;

  function automatic floor_t floor_map(input logic [7:0] code);
    floor_t f;
    f.vld   = 1'b1;
    f.floor = 3'd0;
    case (code)
      SC_KEY0: f.floor = 3'd0;
      SC_KEY1: f.floor = 3'd1;
      SC_KEY2: f.floor = 3'd2;
      SC_KEY3: f.floor = 3'd3;
      SC_KEY4: f.floor = 3'd4;
      SC_KEY5: f.floor = 3'd5;
      default: f.vld   = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: pin conditioning and 11-bit PS/2 frame receiver.
// PS2_PARITY_CHECK_EN: when defined, bad odd parity raises rx_err.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic           c_s1_q, c_s2_q;
  logic           d_s1_q, d_s2_q;
  logic           filt_q;
  logic [FCW-1:0] fcnt_q;
  logic           fall_q;
  rx_state_e      state_q, state_d;
  logic [3:0]     bit_q;
  logic [10:0]    shift_q;
  logic [TCW-1:0] tmo_q;
  logic           tmo_hit;
  logic           par_ok;
  logic           frame_ok;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      c_s1_q <= ps2c;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2d;
      d_s2_q <= d_s1_q;
    end
  end

  // A new clock level must persist FILTER_LEN cycles to be accepted
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (c_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= c_s2_q;
        fcnt_q <= '0;
        fall_q <= ~c_s2_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign tmo_hit = (tmo_q == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall_q) state_d = RX_SHIFT;
      RX_SHIFT: begin
        if (fall_q && bit_q == 4'd10) state_d = RX_DONE;
        else if (!fall_q && tmo_hit)  state_d = RX_IDLE;
      end
      RX_DONE:  state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= '0;
      shift_q <= '0;
      tmo_q   <= '0;
    end else begin
      if (fall_q && state_q != RX_DONE)
        shift_q <= {d_s2_q, shift_q[10:1]};
      if (state_q == RX_IDLE)
        bit_q <= fall_q ? 4'd1 : 4'd0;
      else if (state_q == RX_SHIFT && fall_q)
        bit_q <= bit_q + 4'd1;
      if (state_q != RX_SHIFT || fall_q)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^shift_q[9:1];
`else
  // parity bit is captured but never rejects a frame
  assign par_ok = shift_q[9] | 1'b1;
`endif

  assign frame_ok = ~shift_q[0] & shift_q[10] & par_ok;
  assign rx_byte  = shift_q[8:1];

  always_comb begin
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    unique case (state_q)
      RX_DONE: begin
        rx_valid = frame_ok;
        rx_err   = ~frame_ok;
      end
      RX_SHIFT: rx_err = ~fall_q & tmo_hit;
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_floor_decoder.sv
// ps2_floor_decoder: PS/2 frames to one-hot floor request pulses.
// PS2_PARITY_CHECK_EN (see ps2_rx_frame) enables parity rejection.
module ps2_floor_decoder
  import ps2_pkg::*;
#(
  parameter int NUM_FLOORS  = 6,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic                  ps2c,
  input  logic                  ps2d,
  output logic [NUM_FLOORS-1:0] req_pulse,
  output logic [7:0]            scan_code,
  output logic                  scan_valid,
  output logic                  frame_err
);

  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic                  rx_err;
  logic [7:0]            code_q;
  dec_state_e            dec_q, dec_d;
  floor_t                fm;
  logic                  hit;
  logic [NUM_FLOORS-1:0] req_q, req_d;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .ps2c    (ps2c),
    .ps2d    (ps2d),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      dec_q  <= DEC_NORMAL;
      req_q  <= '0;
      code_q <= '0;
    end else begin
      dec_q <= dec_d;
      req_q <= req_d;
      if (rx_valid) code_q <= rx_byte;
    end
  end

  always_comb begin
    dec_d = dec_q;
    if (rx_valid) begin
      unique case (dec_q)
        DEC_NORMAL: begin
          if (rx_byte == SC_BREAK)    dec_d = DEC_BREAK;
          else if (rx_byte == SC_EXT) dec_d = DEC_EXT;
        end
        DEC_EXT:
          dec_d = (rx_byte == SC_BREAK) ? DEC_BREAK : DEC_NORMAL;
        default: dec_d = DEC_NORMAL;
      endcase
    end
  end

  // Floors beyond NUM_FLOORS simply match no output bit
  always_comb begin
    fm    = floor_map(rx_byte);
    hit   = rx_valid & fm.vld & (dec_q == DEC_NORMAL);
    req_d = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      req_d[i] = hit & (fm.floor == 3'(i));
  end

  assign req_pulse  = req_q;
  assign scan_valid = rx_valid;
  assign frame_err  = rx_err;
  assign scan_code  = rx_valid ? rx_byte : code_q;

endmodule

// File: tb/tb_ps2_floor_decoder.sv
// tb_ps2_floor_decoder: PS/2 frame stimulus with a key-sequence
// reference model for the floor decoder.
module tb_ps2_floor_decoder;

  localparam int NF   = 6;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2c = 1'b1;
  logic          ps2d = 1'b1;
  logic [NF-1:0] req_pulse;
  logic [7:0]    scan_code;
  logic          scan_valid;
  logic          frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;
  int errs = 0;

  logic [7:0]    vq[$];
  int            vcyc[$];
  logic [NF-1:0] pq[$];
  int            pcyc[$];
  logic [7:0]    seq[$];
  logic [NF-1:0] ep[$];
  logic [NF-1:0] prev_req = '0;
  logic [7:0]    keys[NF] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

  always #10 clk = ~clk;

  ps2_floor_decoder #(
    .NUM_FLOORS (NF),
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50M   (clk),
    .rst_n     (rst_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .req_pulse (req_pulse),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_valid) begin
        vq.push_back(scan_code);
        vcyc.push_back(cyc);
      end
      if (frame_err) errs++;
      if (req_pulse != '0) begin
        pq.push_back(req_pulse);
        pcyc.push_back(cyc);
        n_chk++;
        if (!$onehot(req_pulse) || prev_req != '0) begin
          n_fail++;
          $display("FAIL pulse_shape: req_pulse=%b prev=%b, need one-hot single cycle",
                   req_pulse, prev_req);
        end
      end
      if (scan_valid && frame_err) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe_excl: scan_valid and frame_err both 1, need at most one");
      end
    end
    prev_req = req_pulse;
  end

  task automatic clear_logs();
    vq.delete();
    vcyc.delete();
    pq.delete();
    pcyc.delete();
    errs = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (200) @(negedge clk);
  endtask

  task automatic run_seq();
    foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b0, 11);
  endtask

  // Parse a byte stream: F0 swallows the next byte, E0 swallows the
  // next byte (or F0 plus one more); plain floor keys request a floor.
  task automatic build_expect();
    int i;
    int n;
    ep.delete();
    n = seq.size();
    i = 0;
    while (i < n) begin
      if (seq[i] == 8'hF0) begin
        i += 2;
      end else if (seq[i] == 8'hE0) begin
        if (i + 1 < n && seq[i+1] == 8'hF0) i += 3;
        else i += 2;
      end else begin
        for (int k = 0; k < NF; k++)
          if (keys[k] == seq[i]) ep.push_back(NF'(1) << k);
        i++;
      end
    end
  endtask

  function automatic bit pulses_match();
    bit ok;
    ok = (pq.size() == ep.size());
    foreach (ep[i]) if (ok && pq[i] !== ep[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk += 4;
    if (req_pulse !== '0) begin
      n_fail++; $display("FAIL reset_req: got %b need 0", req_pulse);
    end
    if (scan_code !== 8'h00) begin
      n_fail++; $display("FAIL reset_code: got %h need 00", scan_code);
    end
    if (scan_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b need 0", scan_valid);
    end
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b need 0", frame_err);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_make();
    int lat;
    clear_logs();
    send_frame(8'h16, 1'b0, 1'b0, 11);
    n_chk += 5;
    if (vq.size() != 1 || vq[0] !== 8'h16) begin
      n_fail++; $display("FAIL single_valid: got %0d strobes, need one 0x16", vq.size());
    end
    if (pq.size() != 1 || pq[0] !== 6'b000010) begin
      n_fail++; $display("FAIL single_pulse: got %0d pulses, need one 000010", pq.size());
    end
    if (pq.size() == 1 && vq.size() == 1 && pcyc[0] != vcyc[0] + 1) begin
      n_fail++; $display("FAIL single_lag: pulse at %0d valid at %0d, need +1",
                         pcyc[0], vcyc[0]);
    end
    lat = (vcyc.size() > 0) ? vcyc[0] - last_fall : -1;
    if (lat < FL + 2 || lat > FL + 5) begin
      n_fail++; $display("FAIL single_latency: got %0d need %0d..%0d", lat, FL + 2, FL + 5);
    end
    if (scan_code !== 8'h16 || errs != 0) begin
      n_fail++; $display("FAIL single_hold: code %h errs %0d need 16/0", scan_code, errs);
    end
  endtask

  task automatic test_break_seq();
    clear_logs();
    seq = '{8'h2E, 8'hF0, 8'h2E};
    run_seq();
    n_chk += 2;
    if (pq.size() != 1 || pq[0] !== 6'b100000) begin
      n_fail++; $display("FAIL break_pulse: got %0d pulses, need one 100000", pq.size());
    end
    if (vq.size() != 3) begin
      n_fail++; $display("FAIL break_valid: got %0d strobes need 3", vq.size());
    end
  endtask

  task automatic test_frame_errors();
    clear_logs();
    send_frame(8'h16, 1'b1, 1'b0, 11);
    n_chk += 2;
`ifdef PS2_PARITY_CHECK_EN
    if (errs != 1 || vq.size() != 0) begin
      n_fail++; $display("FAIL parity_err: errs %0d strobes %0d need 1/0", errs, vq.size());
    end
    if (pq.size() != 0 || scan_code !== 8'h2E) begin
      n_fail++; $display("FAIL parity_drop: pulses %0d code %h need 0/2e", pq.size(), scan_code);
    end
`else
    if (errs != 0 || vq.size() != 1) begin
      n_fail++; $display("FAIL parity_ign: errs %0d strobes %0d need 0/1", errs, vq.size());
    end
    if (pq.size() != 1 || pq[0] !== 6'b000010) begin
      n_fail++; $display("FAIL parity_pulse: got %0d pulses need one 000010", pq.size());
    end
`endif
    clear_logs();
    send_frame(8'h25, 1'b0, 1'b1, 11);
    n_chk++;
    if (errs != 1 || vq.size() != 0 || pq.size() != 0) begin
      n_fail++; $display("FAIL stop_err: errs %0d strobes %0d pulses %0d need 1/0/0",
                         errs, vq.size(), pq.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_frame(8'h1E, 1'b0, 1'b0, 5);
    repeat (TO * 6 / 5) @(negedge clk);
    n_chk++;
    if (errs != 1 || vq.size() != 0) begin
      n_fail++; $display("FAIL timeout_err: errs %0d strobes %0d need 1/0", errs, vq.size());
    end
    send_frame(8'h1E, 1'b0, 1'b0, 11);
    n_chk++;
    if (errs != 1 || pq.size() != 1 || pq[0] !== 6'b000100) begin
      n_fail++; $display("FAIL timeout_next: errs %0d pulses %0d need 1/one 000100",
                         errs, pq.size());
    end
  endtask

  task automatic test_extended();
    clear_logs();
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h45};
    run_seq();
    n_chk++;
    if (pq.size() != 1 || pq[0] !== 6'b000001) begin
      n_fail++; $display("FAIL ext_pulse: got %0d pulses need one 000001", pq.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_frame(8'h26, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (req_pulse !== '0 || scan_valid !== 1'b0 || frame_err !== 1'b0 ||
        scan_code !== 8'h00) begin
      n_fail++; $display("FAIL midrst_out: req %b valid %b err %b code %h need all 0",
                         req_pulse, scan_valid, frame_err, scan_code);
    end
    rst_n = 1'b1;
    repeat (TO + 100) @(negedge clk);
    ps2c = 1'b0;
    @(negedge clk);
    ps2c = 1'b1;
    repeat (100) @(negedge clk);
    n_chk++;
    if (pq.size() != 0 || vq.size() != 0 || errs != 0) begin
      n_fail++; $display("FAIL midrst_quiet: pulses %0d strobes %0d errs %0d need 0",
                         pq.size(), vq.size(), errs);
    end
    send_frame(8'h26, 1'b0, 1'b0, 11);
    n_chk++;
    if (pq.size() != 1 || pq[0] !== 6'b001000 || errs != 0) begin
      n_fail++; $display("FAIL midrst_next: pulses %0d errs %0d need one 001000",
                         pq.size(), errs);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[10];
    bit ok;
    for (int r = 0; r < 3; r++) begin
      pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
               8'hF0, 8'hE0, 8'h75, 8'($urandom)};
      seq.delete();
      for (int j = 0; j < 6; j++) seq.push_back(pool[$urandom_range(0, 9)]);
      seq.push_back(8'h1C);
      clear_logs();
      run_seq();
      build_expect();
      ok = (vq.size() == seq.size());
      foreach (seq[i]) if (ok && vq[i] !== seq[i]) ok = 1'b0;
      n_chk += 2;
      if (!ok) begin
        n_fail++; $display("FAIL rand_codes: round %0d got %0d strobes need %0d",
                           r, vq.size(), seq.size());
      end
      if (!pulses_match() || errs != 0) begin
        n_fail++; $display("FAIL rand_pulses: round %0d got %0d pulses need %0d errs %0d",
                           r, pq.size(), ep.size(), errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break_seq();
    test_frame_errors();
    test_timeout();
    test_extended();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
